// File: rtl/rf_pkg.sv
// Register-file shared definitions: bank geometry, the zero-register address
// and the writeback requester indices.
package rf_pkg;

   localparam int RF_ADDR_W    = 5;
   localparam int RF_DATA_W    = 32;
   localparam int RF_NUM_REGS  = 32;
   localparam int RF_ZERO_ADDR = 0;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_MUL = 2'd2
   } wb_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback-request and register-bank write bus of rf_write_arbiter.
// When RF_WR_FWD_EN is defined, the bus also carries the read-forwarding compare signals.
interface rf_write_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    hold;
   logic [ADDR_W-1:0]       rf_addr_d;
   logic [DATA_W-1:0]       rf_data;
   logic                    rf_write;
   logic                    collision;

`ifdef RF_WR_FWD_EN
   logic [ADDR_W-1:0]       rd_addr_a;
   logic [ADDR_W-1:0]       rd_addr_b;
   logic                    fwd_a_hit;
   logic                    fwd_b_hit;
   logic [DATA_W-1:0]       fwd_a_data;
   logic [DATA_W-1:0]       fwd_b_data;

   modport master (
      output req_valid, req_addr, req_data, hold, rd_addr_a, rd_addr_b,
      input  req_ready, rf_addr_d, rf_data, rf_write, collision,
             fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
   );
   modport slave (
      input  req_valid, req_addr, req_data, hold, rd_addr_a, rd_addr_b,
      output req_ready, rf_addr_d, rf_data, rf_write, collision,
             fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
   );
`else
   modport master (
      output req_valid, req_addr, req_data, hold,
      input  req_ready, rf_addr_d, rf_data, rf_write, collision
   );
   modport slave (
      input  req_valid, req_addr, req_data, hold,
      output req_ready, rf_addr_d, rf_data, rf_write, collision
   );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: a one-hot combinational grant that searches
// from a rotating pointer, which moves past the winner after each grant.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         enable,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_p0;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] idx_v;
   logic             found;
   int               idx;
   int               nidx;

   always_comb begin
      grant   = '0;
      ptr_nxt = ptr_p0;
      found   = 1'b0;
      idx     = 0;
      nidx    = 0;
      idx_v   = '0;
      if (enable) begin
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr_p0) + k;
            if (idx >= N) idx = idx - N;
            idx_v = PTR_W'(idx);
            if (!found && req[idx_v]) begin
               found        = 1'b1;
               grant[idx_v] = 1'b1;
               nidx         = idx + 1;
               if (nidx >= N) nidx = 0;
               ptr_nxt      = PTR_W'(nidx);
            end
         end
      end
   end

   // p0 -> p1: pointer advances only on a grant (ptr_nxt defaults to hold)
   always_ff @(posedge clk) begin
      if (reset) ptr_p0 <= '0;
      else       ptr_p0 <= ptr_nxt;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among N_REQ writeback sources,
// with a registered write stage, zero-register filter and collision flag; define RF_WR_FWD_EN for read forwarding.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int N_REQ            = 3,
   parameter int ADDR_W           = RF_ADDR_W,
   parameter int DATA_W           = RF_DATA_W,
   parameter bit ZERO_REG_PROTECT = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   rf_write_arbiter_if.slave  bus
);

   logic [N_REQ-1:0]  grant_p0;
   logic              accept_p0;
   logic              zero_hit_p0;
   logic              wr_p0;
   logic              coll_p0;
   logic [ADDR_W-1:0] sel_addr_p0;
   logic [DATA_W-1:0] sel_data_p0;

   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [DATA_W-1:0] data_p1;
   logic              coll_p1;

   function automatic logic any_collision(input logic [N_REQ-1:0]        v,
                                          input logic [N_REQ*ADDR_W-1:0] a);
      any_collision = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = i + 1; j < N_REQ; j++) begin
            if (v[i] && v[j] && (a[i*ADDR_W +: ADDR_W] == a[j*ADDR_W +: ADDR_W]))
               any_collision = 1'b1;
         end
      end
   endfunction

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    (bus.req_valid),
      .enable (!bus.hold && !reset),
      .grant  (grant_p0)
   );

   always_comb begin
      sel_addr_p0 = '0;
      sel_data_p0 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_p0[i]) begin
            sel_addr_p0 = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_data_p0 = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // A write to r0 is still accepted (ready, pointer moves) but never reaches the bank
   assign accept_p0   = |grant_p0;
   assign zero_hit_p0 = ZERO_REG_PROTECT && (sel_addr_p0 == ADDR_W'(RF_ZERO_ADDR));
   assign wr_p0       = accept_p0 && !zero_hit_p0;
   assign coll_p0     = any_collision(bus.req_valid, bus.req_addr);

   // p0 -> p1: output stage; addr/data hold when idle so addr_d stays stable as write drops
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         coll_p1 <= 1'b0;
      end else begin
         vld_p1  <= wr_p0;
         coll_p1 <= coll_p0;
         if (wr_p0) begin
            addr_p1 <= sel_addr_p0;
            data_p1 <= sel_data_p0;
         end
      end
   end

   assign bus.req_ready = grant_p0;
   assign bus.rf_write  = vld_p1;
   assign bus.rf_addr_d = addr_p1;
   assign bus.rf_data   = data_p1;
   assign bus.collision = coll_p1;

`ifdef RF_WR_FWD_EN
   // The bank commits at the end of the write cycle, so readers see the in-flight value here
   assign bus.fwd_a_hit  = vld_p1 && (addr_p1 == bus.rd_addr_a);
   assign bus.fwd_b_hit  = vld_p1 && (addr_p1 == bus.rd_addr_b);
   assign bus.fwd_a_data = data_p1;
   assign bus.fwd_b_data = data_p1;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reference arbitration model plus a write scoreboard.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bit            v [N];
   logic [AW-1:0] a [N];
   logic [DW-1:0] d [N];
   bit            keep;
   bit            hold_r;

   int            mptr;
   bit            m_wr;
   bit            m_coll;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   wr_t           sb [$];
   logic [DW-1:0] bank [32];

   rf_write_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   rf_write_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG_PROTECT(1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at edge+1, check grant, step the model, check registered outputs
   task automatic cycle();
      int            w;
      logic [N-1:0]  eg;
      bit            cn;
      bit            nwr;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]           = v[i];
         bus.req_addr[i*AW +: AW]   = a[i];
         bus.req_data[i*DW +: DW]   = d[i];
      end
      bus.hold = hold_r;
`ifdef RF_WR_FWD_EN
      bus.rd_addr_a = m_addr;
      bus.rd_addr_b = m_addr ^ 5'd1;
`endif
      #1;
      w  = -1;
      eg = '0;
      if (!hold_r && !reset) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (w < 0 && v[i]) w = i;
         end
      end
      if (w >= 0) eg[w] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(eg));
`ifdef RF_WR_FWD_EN
      check("fwd_a_hit", 64'(bus.fwd_a_hit), 64'(m_wr));
      check("fwd_a_data", 64'(bus.fwd_a_data), 64'(m_data));
      check("fwd_b_hit", 64'(bus.fwd_b_hit), 64'd0);
`endif
      cn = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (v[i] && v[j] && a[i] == a[j]) cn = 1'b1;
      nwr = (w >= 0) && (a[w] != '0);
      if (nwr) sb.push_back('{addr: a[w], data: d[w]});
      @(posedge clk);
      #1;
      if (reset) begin
         mptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_coll = 1'b0;
      end else begin
         m_coll = cn;
         m_wr   = nwr;
         if (w >= 0) begin
            if (nwr) begin
               m_addr = a[w];
               m_data = d[w];
            end
            mptr = (w + 1) % N;
            if (!keep) v[w] = 1'b0;
         end
      end
      check("rf_write", 64'(bus.rf_write), 64'(m_wr));
      check("rf_addr_d", 64'(bus.rf_addr_d), 64'(m_addr));
      check("rf_data", 64'(bus.rf_data), 64'(m_data));
      check("collision", 64'(bus.collision), 64'(m_coll));
   endtask

   // Scoreboard: every bank write must match the oldest expected write
   always @(negedge clk) begin
      if (bus.rf_write === 1'b1) begin
         wr_t e;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=%0h expected=none", bus.rf_addr_d);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_addr", 64'(bus.rf_addr_d), 64'(e.addr));
            check("sb_data", 64'(bus.rf_data), 64'(e.data));
            bank[bus.rf_addr_d] = bus.rf_data;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; hold_r = 1'b0; keep = 1'b0;
      mptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_coll = 1'b0;
      for (int i = 0; i < N; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end
      for (int r = 0; r < 32; r++) bank[r] = '0;
      repeat (2) cycle();
      reset = 1'b0;

      // single requester
      v[int'(WB_ALU)] = 1'b1; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
      cycle();
      cycle();

      // all three continuously from ptr=0
      reset = 1'b1; cycle(); reset = 1'b0;
      keep = 1'b1;
      v[0] = 1'b1; a[0] = 5'd1; d[0] = 32'hA1;
      v[1] = 1'b1; a[1] = 5'd2; d[1] = 32'hA2;
      v[2] = 1'b1; a[2] = 5'd3; d[2] = 32'hA3;
      repeat (6) cycle();
      keep = 1'b0;
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      repeat (2) cycle();

      // same-address collision
      reset = 1'b1; cycle(); reset = 1'b0;
      v[int'(WB_ALU)] = 1'b1; a[0] = 5'd7; d[0] = 32'h11;
      v[int'(WB_MUL)] = 1'b1; a[2] = 5'd7; d[2] = 32'h22;
      repeat (3) cycle();
      check("bank7_last_wins", 64'(bank[7]), 64'h22);

      // zero-register write dropped, pointer still advances
      v[int'(WB_MEM)] = 1'b1; a[1] = 5'd0; d[1] = 32'hFFFF;
      cycle();
      v[0] = 1'b1; a[0] = 5'd4; d[0] = 32'h44;
      v[2] = 1'b1; a[2] = 5'd6; d[2] = 32'h66;
      repeat (3) cycle();
      check("bank0_untouched", 64'(bank[0]), 64'h0);

      // hold after a grant
      v[0] = 1'b1; a[0] = 5'd9; d[0] = 32'h99;
      cycle();
      hold_r = 1'b1;
      v[0] = 1'b1; a[0] = 5'd10; d[0] = 32'hAA;
      repeat (3) cycle();
      hold_r = 1'b0;
      repeat (2) cycle();

      // reset with requests valid and a write pending
      keep = 1'b1;
      v[0] = 1'b1; a[0] = 5'd11; d[0] = 32'h111;
      v[1] = 1'b1; a[1] = 5'd12; d[1] = 32'h122;
      cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      repeat (2) cycle();
      keep = 1'b0;
      for (int i = 0; i < N; i++) v[i] = 1'b0;
      repeat (2) cycle();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of the 32x32 register bank between N writeback requesters (ALU, load unit, multiplier, ...). Valid/ready handshake per requester, round-robin arbitration, one grant per cycle. Registered output stage drives the bank's addr_d/data/write. Sits between the writeback sources and the register bank.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width
ZERO_REG_PROTECT, 1, 1 = accepted writes to register 0 are dropped (never reach the bank)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester write request
req_addr  input  N_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot grant; request accepted on a cycle with valid&ready
hold  input  1  pipeline freeze; no grants while high
rf_addr_d  output  ADDR_W  to register bank addr_d
rf_data  output  DATA_W  to register bank data
rf_write  output  1  to register bank write
collision  output  1  registered flag: in the previous cycle ≥2 valid requesters targeted the same address

Behaviour:
- Reset (reset=1 at a clock edge): rf_write=0, rf_addr_d=0, rf_data=0, collision=0, rr pointer=0. req_ready forced to 0 while reset=1. In-flight output-stage write is discarded.
- Arbitration (combinational): req_ready is 0 when hold=1 or reset=1. Otherwise, search requesters starting at the rr pointer, wrapping modulo N_REQ. Assert req_ready only for the first valid requester. At most one bit set.
- Pointer update: on a grant to requester i, ptr <= (i+1) mod N_REQ. With no grant, ptr holds.
- Requester contract: once valid is raised, valid, addr and data hold stable until ready. The arbiter does not buffer losers.
- Output stage: on a grant at cycle t, rf_addr_d/rf_data capture the winner's addr/data at edge t. rf_write=1 for exactly cycle t+1. Latency is 1 cycle. Throughput is 1 write per cycle.
- With no grant, rf_write <= 0. rf_addr_d and rf_data hold their last values, so addr_d is stable while write deasserts.
- Zero register: if ZERO_REG_PROTECT=1 and the granted addr is 0, the request is still accepted (ready=1) and the pointer still advances. rf_write stays 0 and rf_addr_d/rf_data do not update.
- Same-address collision: the requesters are served in round-robin order, and the last write served wins. collision is updated every cycle as a compare over all valid pairs, registered (1-cycle delay). It is not gated by hold.
- hold=1 mid-stream: a write already captured still completes (rf_write=1 in the next cycle). No new grant is made until hold=0.
- reset during a pending request: the requester's valid may stay high. After reset it competes starting from ptr=0.

Optional Feature:
RF_WR_FWD_EN: adds inputs rd_addr_a and rd_addr_b (ADDR_W each) and outputs fwd_a_hit, fwd_b_hit (1 each) and fwd_a_data, fwd_b_data (DATA_W each). These are combinational: hit = rf_write && (rf_addr_d == rd_addr_x), data = rf_data. The bank updates only at the end of the write cycle, so this lets readers see the in-flight value. Without the macro these ports are absent and no compare logic is built.

Decomposition:
- Shared package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32, RF_ZERO_ADDR=0. Also a requester-index enum: WB_ALU=0, WB_MEM=1, WB_MUL=2.
- One natural sub-module: rr_arbiter. It is a generic N-way round-robin grant with pointer register, inputs req and enable, outputs a one-hot grant. rf_write_arbiter instantiates it and adds the muxing, output register, zero-reg filter, collision detect and forwarding.

Test Plan:
- Single requester: req0 valid, addr=5, data=0xDEADBEEF at cycle t → ready0=1 at t. At t+1, rf_write=1, rf_addr_d=5, rf_data=0xDEADBEEF. At t+2, rf_write=0 and addr/data unchanged.
- All three requesters valid continuously (addr 1, 2, 3) from ptr=0 → grants 0,1,2,0,... on consecutive cycles. rf_write stays 1 every cycle after the first, with addr sequence 1,2,3,1.
- Same address: req0 and req2 both target addr=7 with data 0x11 and 0x22, ptr=0 → collision=1 one cycle later. Writes occur in order 0x11 then 0x22, so the bank ends holding 0x22.
- Zero-register write with ZERO_REG_PROTECT=1: req1 addr=0, data=0xFFFF → ready1=1 and ptr becomes 2. rf_write stays 0 and rf_addr_d/rf_data keep their previous values.
- hold raised the cycle after a grant → the captured write completes (rf_write=1 once). Then no ready for 3 hold cycles. On hold=0, the pending request is granted in the same cycle.
- reset asserted while req0 and req1 are valid and an output write is pending → the next cycle has rf_write=0 and ptr=0. After reset deasserts, req0 is granted first. With RF_WR_FWD_EN, rd_addr_a=rf_addr_d during a write gives fwd_a_hit=1 and fwd_a_data=rf_data.
